// File: rtl/crf_pkg.sv
// Shared widths and node-table entry layout for the CRF/NLP decision-tree pipeline.
// Pipeline registers and traversal stages import this so entry fields line up everywhere.
package crf_pkg;

    localparam int SAMPLE_W = 256;
    localparam int FEAT_W   = 16;
    localparam int NUM_FEAT = 16;
    localparam int NODE_W   = 8;
    localparam int ENTRY_W  = 37;

    localparam int ENTRY_LEFT_LSB  = 0;
    localparam int ENTRY_LEFT_W    = 8;
    localparam int ENTRY_RIGHT_LSB = 8;
    localparam int ENTRY_RIGHT_W   = 8;
    localparam int ENTRY_THR_LSB   = 16;
    localparam int ENTRY_THR_W     = 16;
    localparam int ENTRY_FSEL_LSB  = 32;
    localparam int ENTRY_FSEL_W    = 4;
    localparam int ENTRY_LEAF_BIT  = 36;

    typedef struct packed {
        logic                     isLeaf;
        logic [ENTRY_FSEL_W-1:0]  featSel;
        logic [ENTRY_THR_W-1:0]   threshold;
        logic [ENTRY_RIGHT_W-1:0] rightChild;
        logic [ENTRY_LEFT_W-1:0]  leftChild;
    } node_entry_t;

    // leftChild doubles as the class id when isLeaf is set.
    function automatic node_entry_t unpack_entry(input logic [ENTRY_W-1:0] raw);
        node_entry_t e;
        e.isLeaf     = raw[ENTRY_LEAF_BIT];
        e.featSel    = raw[ENTRY_FSEL_LSB +: ENTRY_FSEL_W];
        e.threshold  = raw[ENTRY_THR_LSB +: ENTRY_THR_W];
        e.rightChild = raw[ENTRY_RIGHT_LSB +: ENTRY_RIGHT_W];
        e.leftChild  = raw[ENTRY_LEFT_LSB +: ENTRY_LEFT_W];
        return e;
    endfunction

endpackage

// File: rtl/node_table_ram.sv
// Node table: one write port, one synchronous read-first read port, contents not reset.
module node_table_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 37
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [2**ADDR_W];
    logic [DATA_W-1:0] rdata_q;

    // Read samples the array before this edge's write lands, so a colliding read sees old data.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/tree_node_stage.sv
// One decision-tree depth level: S1 reads the node table, S2 compares the selected feature
// against the node threshold and emits the next node index or the leaf class.
module tree_node_stage
    import crf_pkg::ENTRY_W, crf_pkg::node_entry_t, crf_pkg::unpack_entry;
#(
    parameter int STAGE    = 0,
    parameter int SAMPLE_W = crf_pkg::SAMPLE_W,
    parameter int FEAT_W   = crf_pkg::FEAT_W,
    parameter int NUM_FEAT = crf_pkg::NUM_FEAT,
    parameter int NODE_W   = crf_pkg::NODE_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sampleData_i,
    input  logic [NODE_W-1:0]   nodeIndexIn,
    input  logic                leafIn,
    input  logic                valid_i,
    output logic                ready_o,
    output logic [SAMPLE_W-1:0] sampleData_o,
    output logic [NODE_W-1:0]   nodeIndexOut,
    output logic                leafOut,
    output logic                valid_o,
    input  logic                ready_i,
    input  logic                cfgWe,
    input  logic [NODE_W-1:0]   cfgAddr,
    input  logic [ENTRY_W-1:0]  cfgData,
    output logic [15:0]         outCount
);

    if (SAMPLE_W != NUM_FEAT * FEAT_W || STAGE < 0) begin : g_bad_cfg
        $error("tree_node_stage: SAMPLE_W must equal NUM_FEAT*FEAT_W");
    end

    logic                s1Valid_q;
    logic [SAMPLE_W-1:0] s1Sample_q;
    logic [NODE_W-1:0]   s1Node_q;
    logic                s1Leaf_q;

    logic                s2Valid_q;
    logic [SAMPLE_W-1:0] s2Sample_q;
    logic [NODE_W-1:0]   s2Node_q;
    logic                s2Leaf_q;
    logic [15:0]         outCount_q;

    logic                advance;
    logic [NODE_W-1:0]   readAddr;
    logic [ENTRY_W-1:0]  rdData;
    node_entry_t         entry;
    logic [FEAT_W-1:0]   feature;
    logic [NODE_W-1:0]   s2Node_d;
    logic                s2Leaf_d;

    assign advance  = !s2Valid_q || ready_i;
    assign ready_o  = advance;
    // While stalled, keep re-reading the held index so the entry feeding S2 stays put.
    assign readAddr = advance ? nodeIndexIn : s1Node_q;

    node_table_ram #(
        .ADDR_W(NODE_W),
        .DATA_W(ENTRY_W)
    ) u_table (
        .clk    (clk),
        .we_i   (cfgWe),
        .waddr_i(cfgAddr),
        .wdata_i(cfgData),
        .raddr_i(readAddr),
        .rdata_o(rdData)
    );

    assign entry = unpack_entry(rdData);

    always_comb begin
        feature = '0;
        for (int k = 0; k < NUM_FEAT; k++) begin
            if (int'(entry.featSel) == k) begin
                feature = s1Sample_q[k*FEAT_W +: FEAT_W];
            end
        end
    end

    always_comb begin
        s2Node_d = s1Node_q;
        s2Leaf_d = 1'b1;
        if (!s1Leaf_q) begin
            if (entry.isLeaf) begin
                s2Node_d = NODE_W'(entry.leftChild);
            end else begin
                s2Leaf_d = 1'b0;
                s2Node_d = (feature >= entry.threshold) ? NODE_W'(entry.rightChild)
                                                        : NODE_W'(entry.leftChild);
            end
        end
    end

    // S1 and S2 only ever move together, so a stall freezes the whole stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1Valid_q  <= 1'b0;
            s1Sample_q <= '0;
            s1Node_q   <= '0;
            s1Leaf_q   <= 1'b0;
            s2Valid_q  <= 1'b0;
            s2Sample_q <= '0;
            s2Node_q   <= '0;
            s2Leaf_q   <= 1'b0;
            outCount_q <= '0;
        end else begin
            if (advance) begin
                s1Valid_q  <= valid_i;
                s1Sample_q <= sampleData_i;
                s1Node_q   <= nodeIndexIn;
                s1Leaf_q   <= leafIn;
                s2Valid_q  <= s1Valid_q;
                s2Sample_q <= s1Sample_q;
                s2Node_q   <= s2Node_d;
                s2Leaf_q   <= s2Leaf_d;
            end
            if (s2Valid_q && ready_i) begin
                outCount_q <= outCount_q + 16'd1;
            end
        end
    end

    assign valid_o      = s2Valid_q;
    assign sampleData_o = s2Sample_q;
    assign nodeIndexOut = s2Node_q;
    assign leafOut      = s2Leaf_q;
    assign outCount     = outCount_q;

endmodule

// File: tb/tb_tree_node_stage.sv
// Directed bench for tree_node_stage: compare paths, leaves, streaming, stall, write collision, reset.
module tb_tree_node_stage;

    logic         clk;
    logic         rst_n;
    logic [255:0] sampleData_i;
    logic [7:0]   nodeIndexIn;
    logic         leafIn;
    logic         valid_i;
    logic         ready_o;
    logic [255:0] sampleData_o;
    logic [7:0]   nodeIndexOut;
    logic         leafOut;
    logic         valid_o;
    logic         ready_i;
    logic         cfgWe;
    logic [7:0]   cfgAddr;
    logic [36:0]  cfgData;
    logic [15:0]  outCount;

    int checks;
    int failures;

    tree_node_stage #(
        .STAGE(0), .SAMPLE_W(256), .FEAT_W(16), .NUM_FEAT(16), .NODE_W(8)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .sampleData_i(sampleData_i), .nodeIndexIn(nodeIndexIn), .leafIn(leafIn),
        .valid_i(valid_i), .ready_o(ready_o),
        .sampleData_o(sampleData_o), .nodeIndexOut(nodeIndexOut), .leafOut(leafOut),
        .valid_o(valid_o), .ready_i(ready_i),
        .cfgWe(cfgWe), .cfgAddr(cfgAddr), .cfgData(cfgData), .outCount(outCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [36:0] mkEntry(input logic isLeaf, input logic [3:0] fsel,
                                            input logic [15:0] thr, input logic [7:0] right,
                                            input logic [7:0] left);
        return {isLeaf, fsel, thr, right, left};
    endfunction

    // Every feature carries a tag so samples are distinguishable; feature 3 is the one compared.
    function automatic logic [255:0] mkSample(input logic [15:0] f3, input logic [7:0] tag);
        logic [255:0] s;
        for (int k = 0; k < 16; k++) begin
            s[k*16 +: 16] = {tag, 4'h0, 4'(k)};
        end
        s[3*16 +: 16] = f3;
        return s;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic cfgWrite(input logic [7:0] addr, input logic [36:0] data);
        cfgWe   = 1'b1;
        cfgAddr = addr;
        cfgData = data;
        tick();
        cfgWe   = 1'b0;
    endtask

    task automatic driveOne(input logic [255:0] s, input logic [7:0] node, input logic leaf);
        valid_i      = 1'b1;
        sampleData_i = s;
        nodeIndexIn  = node;
        leafIn       = leaf;
        tick();
        valid_i      = 1'b0;
        leafIn       = 1'b0;
        tick();
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick();
        tick();
        checks += 6;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_o); end
        if (leafOut !== 1'b0) begin failures++; $display("[TB] FAIL reset_leaf: got %b expected 0", leafOut); end
        if (nodeIndexOut !== 8'h00) begin failures++; $display("[TB] FAIL reset_node: got %h expected 00", nodeIndexOut); end
        if (sampleData_o !== 256'h0) begin failures++; $display("[TB] FAIL reset_sample: got %h expected 0", sampleData_o); end
        if (outCount !== 16'h0) begin failures++; $display("[TB] FAIL reset_count: got %h expected 0", outCount); end
        if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL reset_ready: got %b expected 1", ready_o); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_compare;
        logic [255:0] s;
        s = mkSample(16'h1000, 8'h01);
        driveOne(s, 8'h05, 1'b0);
        checks += 4;
        if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL cmp_eq_valid: got %b expected 1", valid_o); end
        if (nodeIndexOut !== 8'h0B) begin failures++; $display("[TB] FAIL cmp_eq_node: got %h expected 0b", nodeIndexOut); end
        if (leafOut !== 1'b0) begin failures++; $display("[TB] FAIL cmp_eq_leaf: got %b expected 0", leafOut); end
        if (sampleData_o !== s) begin failures++; $display("[TB] FAIL cmp_eq_sample: got %h expected %h", sampleData_o, s); end
        tick();
        checks += 1;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL cmp_bubble: got %b expected 0", valid_o); end
        s = mkSample(16'h0FFF, 8'h02);
        driveOne(s, 8'h05, 1'b0);
        checks += 3;
        if (nodeIndexOut !== 8'h0A) begin failures++; $display("[TB] FAIL cmp_lt_node: got %h expected 0a", nodeIndexOut); end
        if (leafOut !== 1'b0) begin failures++; $display("[TB] FAIL cmp_lt_leaf: got %b expected 0", leafOut); end
        if (sampleData_o !== s) begin failures++; $display("[TB] FAIL cmp_lt_sample: got %h expected %h", sampleData_o, s); end
        tick();
    endtask

    task automatic test_leaf;
        driveOne(mkSample(16'hFFFF, 8'h03), 8'h20, 1'b0);
        checks += 3;
        if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL leaf_entry_valid: got %b expected 1", valid_o); end
        if (nodeIndexOut !== 8'h07) begin failures++; $display("[TB] FAIL leaf_entry_class: got %h expected 07", nodeIndexOut); end
        if (leafOut !== 1'b1) begin failures++; $display("[TB] FAIL leaf_entry_flag: got %b expected 1", leafOut); end
        tick();
        driveOne(mkSample(16'h0000, 8'h04), 8'h33, 1'b1);
        checks += 2;
        if (nodeIndexOut !== 8'h33) begin failures++; $display("[TB] FAIL leaf_in_node: got %h expected 33", nodeIndexOut); end
        if (leafOut !== 1'b1) begin failures++; $display("[TB] FAIL leaf_in_flag: got %b expected 1", leafOut); end
        tick();
        checks += 1;
        if (outCount !== 16'd4) begin failures++; $display("[TB] FAIL leaf_count: got %0d expected 4", outCount); end
    endtask

    task automatic test_back_to_back;
        logic [255:0] s [8];
        logic [7:0]   expNode [8];
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            s[i]       = mkSample((i % 2 == 0) ? 16'h1000 + 16'(i) : 16'h0FFF - 16'(i), 8'h40 + 8'(i));
            expNode[i] = (i % 2 == 0) ? 8'h0B : 8'h0A;
        end
        for (int c = 0; c < 9; c++) begin
            if (c < 8) begin
                valid_i = 1'b1; sampleData_i = s[c]; nodeIndexIn = 8'h05; leafIn = 1'b0;
            end else begin
                valid_i = 1'b0;
            end
            tick();
            if (c == 0) begin
                checks += 1;
                if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_first_bubble: got %b expected 0", valid_o); end
            end else begin
                checks += 3;
                if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL b2b_valid[%0d]: got %b expected 1", c-1, valid_o); end
                if (sampleData_o !== s[c-1]) begin failures++; $display("[TB] FAIL b2b_sample[%0d]: got %h expected %h", c-1, sampleData_o, s[c-1]); end
                if (nodeIndexOut !== expNode[c-1]) begin failures++; $display("[TB] FAIL b2b_node[%0d]: got %h expected %h", c-1, nodeIndexOut, expNode[c-1]); end
            end
        end
        tick();
        checks += 2;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL b2b_drain: got %b expected 0", valid_o); end
        if (outCount !== 16'd8) begin failures++; $display("[TB] FAIL b2b_count: got %0d expected 8", outCount); end
    endtask

    task automatic test_stall;
        logic [255:0] s [4];
        for (int i = 0; i < 4; i++) s[i] = mkSample(16'h1000, 8'h60 + 8'(i));
        valid_i = 1'b1; sampleData_i = s[0]; nodeIndexIn = 8'h05; leafIn = 1'b0;
        tick();
        sampleData_i = s[1];
        tick();
        sampleData_i = s[2];
        ready_i = 1'b0;
        #1;
        checks += 1;
        if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready_drop: got %b expected 0", ready_o); end
        for (int c = 0; c < 4; c++) begin
            tick();
            checks += 4;
            if (valid_o !== 1'b1) begin failures++; $display("[TB] FAIL stall_valid[%0d]: got %b expected 1", c, valid_o); end
            if (sampleData_o !== s[0]) begin failures++; $display("[TB] FAIL stall_sample[%0d]: got %h expected %h", c, sampleData_o, s[0]); end
            if (ready_o !== 1'b0) begin failures++; $display("[TB] FAIL stall_ready[%0d]: got %b expected 0", c, ready_o); end
            if (outCount !== 16'd8) begin failures++; $display("[TB] FAIL stall_count[%0d]: got %0d expected 8", c, outCount); end
        end
        ready_i = 1'b1;
        tick();
        checks += 2;
        if (sampleData_o !== s[1]) begin failures++; $display("[TB] FAIL release_s1: got %h expected %h", sampleData_o, s[1]); end
        if (outCount !== 16'd9) begin failures++; $display("[TB] FAIL release_count: got %0d expected 9", outCount); end
        sampleData_i = s[3];
        tick();
        valid_i = 1'b0;
        checks += 1;
        if (sampleData_o !== s[2]) begin failures++; $display("[TB] FAIL release_s2: got %h expected %h", sampleData_o, s[2]); end
        tick();
        checks += 2;
        if (sampleData_o !== s[3] || valid_o !== 1'b1) begin failures++; $display("[TB] FAIL release_s3: got %h expected %h", sampleData_o, s[3]); end
        if (nodeIndexOut !== 8'h0B) begin failures++; $display("[TB] FAIL release_node: got %h expected 0b", nodeIndexOut); end
        tick();
        checks += 2;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL release_drain: got %b expected 0", valid_o); end
        if (outCount !== 16'd12) begin failures++; $display("[TB] FAIL release_total: got %0d expected 12", outCount); end
    endtask

    task automatic test_write_collision;
        logic [255:0] s0;
        logic [255:0] s1;
        s0 = mkSample(16'h1800, 8'h70);
        s1 = mkSample(16'h1800, 8'h71);
        valid_i = 1'b1; sampleData_i = s0; nodeIndexIn = 8'h05; leafIn = 1'b0;
        cfgWe = 1'b1; cfgAddr = 8'h05; cfgData = mkEntry(1'b0, 4'd3, 16'h2000, 8'h0B, 8'h0A);
        tick();
        cfgWe = 1'b0;
        sampleData_i = s1;
        tick();
        valid_i = 1'b0;
        checks += 2;
        if (sampleData_o !== s0) begin failures++; $display("[TB] FAIL wr_old_sample: got %h expected %h", sampleData_o, s0); end
        if (nodeIndexOut !== 8'h0B) begin failures++; $display("[TB] FAIL wr_old_thr: got %h expected 0b", nodeIndexOut); end
        tick();
        checks += 2;
        if (sampleData_o !== s1) begin failures++; $display("[TB] FAIL wr_new_sample: got %h expected %h", sampleData_o, s1); end
        if (nodeIndexOut !== 8'h0A) begin failures++; $display("[TB] FAIL wr_new_thr: got %h expected 0a", nodeIndexOut); end
        tick();
    endtask

    task automatic test_reset_inflight;
        valid_i = 1'b1; sampleData_i = mkSample(16'h0001, 8'h80); nodeIndexIn = 8'h05; leafIn = 1'b0;
        tick();
        sampleData_i = mkSample(16'h0002, 8'h81);
        tick();
        valid_i = 1'b0;
        rst_n = 1'b0;
        tick();
        checks += 3;
        if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_fly_valid: got %b expected 0", valid_o); end
        if (outCount !== 16'd0) begin failures++; $display("[TB] FAIL rst_fly_count: got %0d expected 0", outCount); end
        if (ready_o !== 1'b1) begin failures++; $display("[TB] FAIL rst_fly_ready: got %b expected 1", ready_o); end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks += 2;
            if (valid_o !== 1'b0) begin failures++; $display("[TB] FAIL rst_fly_dropped[%0d]: got %b expected 0", c, valid_o); end
            if (outCount !== 16'd0) begin failures++; $display("[TB] FAIL rst_fly_hold[%0d]: got %0d expected 0", c, outCount); end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        sampleData_i = '0;
        nodeIndexIn = '0;
        leafIn = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b1;
        cfgWe = 1'b0;
        cfgAddr = '0;
        cfgData = '0;
        test_reset();
        cfgWrite(8'h05, mkEntry(1'b0, 4'd3, 16'h1000, 8'h0B, 8'h0A));
        cfgWrite(8'h20, mkEntry(1'b1, 4'd0, 16'h0000, 8'h00, 8'h07));
        test_compare();
        test_leaf();
        test_back_to_back();
        test_stall();
        test_write_collision();
        test_reset_inflight();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/tree_node_stage.md
# tree_node_stage

Decision-tree traversal stage for the CRF/NLP accelerator. It consumes a 256-bit sample and current node index from the upstream pipeline register and looks the node up in a locally loaded node table. It compares the selected 16-bit feature against the node threshold and emits the sample plus the next node index (or the leaf class) to the next pipeline register. One instance serves one tree depth level; instances alternate with pipeline registers down the tree.

## Interface
- STAGE, 0, tree depth level served; informational only, no effect on logic
- SAMPLE_W, 256, sample width; must equal NUM_FEAT*FEAT_W
- FEAT_W, 16, feature and threshold width (unsigned)
- NUM_FEAT, 16, features per sample; feature k = sampleData_i[k*FEAT_W +: FEAT_W]
- NODE_W, 8, node index width; table depth 2**NODE_W
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  synchronous, active-low reset
- sampleData_i  in  SAMPLE_W  sample from upstream register
- nodeIndexIn  in  NODE_W  current node index
- leafIn  in  1  sample already resolved at an earlier level
- valid_i  in  1  upstream data valid
- ready_o  out  1  stage accepts data this cycle
- sampleData_o  out  SAMPLE_W  sample, unchanged
- nodeIndexOut  out  NODE_W  next node index, or class when leafOut=1
- leafOut  out  1  result is a leaf class
- valid_o  out  1  output valid
- ready_i  in  1  downstream accepts
- cfgWe  in  1  node-table write strobe
- cfgAddr  in  NODE_W  node-table write address
- cfgData  in  37  entry: [36] isLeaf, [35:32] featSel, [31:16] threshold, [15:8] rightChild, [7:0] leftChild/class
- outCount  out  16  count of output handshakes, wraps

## Operation
- Two internal stages, S1 (table read) and S2 (compare/output). Each holds a valid bit.
- advance = !valid_o || ready_i. ready_o = advance. This combinational path ready_i -> ready_o is intended. S1 and S2 move only together on advance.
- S1, on advance: capture sample, nodeIndexIn, leafIn, and valid_i. Table read address is nodeIndexIn when advance, else the held S1 index, so the read data stays stable while stalled.
- S2, on advance: take S1 contents.
  - If leafIn was set: pass nodeIndex through, leafOut=1.
  - Else if entry.isLeaf: nodeIndexOut = entry[7:0], leafOut=1.
  - Else compare feature[featSel] against threshold, unsigned. Feature >= threshold gives rightChild; otherwise leftChild. leafOut=0.
- Transfer rules:
  - valid_o and all outputs hold stable while valid_o=1 and ready_i=0.
  - A bubble with valid=0 propagates as valid_o=0.
- Table: synchronous, read-first. A cfgWe write to the address being read in the same cycle returns old data; the new data is seen from the next read. Writes are accepted in any cycle regardless of traffic.
- outCount increments on every cycle with valid_o && ready_i and wraps 0xFFFF -> 0.

## Timing
- Latency: 2 cycles from the accepting edge (valid_i && ready_o) to valid_o, with no stall. Throughput is 1 sample/cycle.
- Reset, while rst_n=0 at a rising edge:
  - valid_o=0, leafOut=0, nodeIndexOut=0, sampleData_o=0, outCount=0.
  - Both internal valid bits are cleared.
  - In-flight samples are dropped.
- Table contents are not reset and are undefined until written.
- ready_o=1 during and after reset while valid_o=0.
- Full stall: with both stages valid and ready_i=0, ready_o=0, nothing moves, and outCount holds.
- ready_i rising after a stall: the held output transfers on that edge and S1 moves to S2 on the same edge.

## Structure
- Package crf_pkg holds the widths (SAMPLE_W, FEAT_W, NODE_W), the node-entry width of 37, and localparams for the entry field bit offsets. The pipeline registers share this package.
- Sub-module node_table_ram: 2**NODE_W x 37, one write port, one synchronous read-first read port, no reset.
- Feature mux and comparator stay in tree_node_stage.

## Test plan
- Table loaded: entry 0x05 = {isLeaf 0, featSel 3, thr 0x1000, right 0x0B, left 0x0A}. Sample feature3=0x1000, node 0x05, ready_i=1 -> 2 cycles later node 0x0B, leafOut 0, same sample. Repeat with feature3=0x0FFF -> node 0x0A.
- Entry 0x20 = {isLeaf 1, class 0x07} -> nodeIndexOut 0x07, leafOut 1. Input leafIn=1, node 0x33 -> output 0x33, leafOut 1, table ignored.
- Back-to-back 8 samples, ready_i=1 -> 8 consecutive valid_o cycles, order preserved, outCount=8.
- Hold ready_i=0 for 4 cycles mid-stream -> ready_o=0 after the pipeline fills, outputs stable, no loss or duplication after release, outCount unchanged during the stall.
- Same-cycle cfgWe to 0x05 (thr 0x2000) and read of 0x05 with feature 0x1800 -> old threshold used (right child). Next sample uses the new threshold (left child).
- Assert rst_n=0 with 2 samples in flight -> next edge valid_o=0, outCount=0, ready_o=1. The samples are never emitted.
